// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low segment patterns {g,f,e,d,c,b,a}
// and active-low anode selects for the four-digit scan.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [3:0] AN_SEL [0:3] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// render as a dash so corrupted time values are visible rather than hidden.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit pattern lookup with dash for 10..15
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed display driver: captures the HH:MM frame at scan
// wrap, applies flash/blink/leading-zero blanking and registers an/seg/dp.
module seg_scan_driver
  import seg7_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scan_sel,
  input  logic [15:0] bcd_time,
  input  logic [3:0]  blink_mask,
  input  logic        alarm_ring,
  input  logic        colon_en,
  input  logic        half_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [15:0] frame_r;
  logic [1:0]  prev_sel_r;
  logic        phase_r;

  logic [3:0]  nibble_s;
  logic [6:0]  dec_s;
  logic        blank_s;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_s;

  // Frame capture only on the 3->0 wrap so a frame is never torn mid-scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_r    <= 16'h0000;
      prev_sel_r <= 2'd0;
      phase_r    <= 1'b1;
    end else begin
      prev_sel_r <= scan_sel;
      if ((prev_sel_r == 2'd3) && (scan_sel == 2'd0)) begin
        frame_r <= bcd_time;
      end
      if (half_tick) begin
        phase_r <= ~phase_r;
      end
    end
  end

  // Select the nibble addressed by the scan counter
  always_comb begin
    nibble_s = frame_r[3:0];
    case (scan_sel)
      2'd0:    nibble_s = frame_r[3:0];
      2'd1:    nibble_s = frame_r[7:4];
      2'd2:    nibble_s = frame_r[11:8];
      2'd3:    nibble_s = frame_r[15:12];
      default: nibble_s = frame_r[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (nibble_s),
    .seg (dec_s)
  );

  // Blanking sources all yield the same dark slot, so they are simply ORed
  always_comb begin
    blank_s = (alarm_ring && !phase_r)
           || (blink_mask[scan_sel] && !phase_r)
           || (LZ_BLANK && (scan_sel == 2'd3) && (frame_r[15:12] == 4'd0));
    an_s  = AN_OFF;
    seg_s = SEG_BLANK;
    dp_s  = 1'b1;
    if (!blank_s) begin
      an_s  = AN_SEL[scan_sel];
      seg_s = dec_s;
      dp_s  = ~((scan_sel == 2'd2) && colon_en && phase_r);
    end else begin
      an_s  = AN_OFF;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a reference model pushes expected
// {an,seg,dp} into a scoreboard, popped and compared one clock later.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  scan_sel = 2'd0;
  logic [15:0] bcd_time = 16'h0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        alarm_ring = 1'b0;
  logic        colon_en = 1'b0;
  logic        half_tick = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb_q[$];
  logic [15:0] m_frame = 16'h0000;
  logic [1:0]  m_prev  = 2'd0;
  logic        m_phase = 1'b1;

  localparam logic [6:0] TBL [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  always #5 clk = ~clk;

  seg_scan_driver #(.LZ_BLANK(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_sel   (scan_sel),
    .bcd_time   (bcd_time),
    .blink_mask (blink_mask),
    .alarm_ring (alarm_ring),
    .colon_en   (colon_en),
    .half_tick  (half_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  function automatic logic [11:0] exp_out(input logic [1:0] sel, input logic [15:0] frm,
                                          input logic ph, input logic [3:0] msk,
                                          input logic ring, input logic col);
    logic [15:0] sh;
    logic [3:0]  d;
    logic        dark;
    logic [3:0]  a;
    logic        p;
    sh   = frm >> (4 * int'(sel));
    d    = sh[3:0];
    dark = (ring && !ph) || (msk[sel] && !ph) || ((sel == 2'd3) && (d == 4'd0));
    if (dark) return {4'hF, 7'h7F, 1'b1};
    a = ~(4'b0001 << sel);
    p = !((sel == 2'd2) && col && ph);
    return {a, TBL[d], p};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One scan slot: drive at negedge, predict, clock, then compare at negedge
  task automatic cycle(input logic [1:0] sel, input logic ht, input string tag);
    logic [11:0] expv;
    scan_sel  = sel;
    half_tick = ht;
    sb_q.push_back(exp_out(sel, m_frame, m_phase, blink_mask, alarm_ring, colon_en));
    if ((m_prev == 2'd3) && (sel == 2'd0)) m_frame = bcd_time;
    if (ht) m_phase = ~m_phase;
    m_prev = sel;
    @(posedge clk);
    @(negedge clk);
    half_tick = 1'b0;
    expv = sb_q.pop_front();
    check(tag, {an, seg, dp}, expv);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hold", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    rst = 1'b0;

    cycle(2'd0, 1'b0, "zero_s0");
    cycle(2'd1, 1'b0, "zero_s1");
    cycle(2'd2, 1'b0, "zero_s2");
    cycle(2'd3, 1'b0, "zero_s3");
    check("lz_blank_s3", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    cycle(2'd0, 1'b0, "zero_s0b");
    check("zero_digit_s0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

    // asynchronous reset away from any clock edge
    #2 rst = 1'b1;
    #1 check("async_rst", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    m_frame = 16'h0000;
    m_prev  = 2'd0;
    m_phase = 1'b1;

    bcd_time = 16'h1245;
    cycle(2'd1, 1'b0, "n_s1");
    cycle(2'd2, 1'b0, "n_s2");
    cycle(2'd3, 1'b0, "n_s3");
    cycle(2'd0, 1'b0, "n_cap");
    check("precap_frame", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    cycle(2'd1, 1'b0, "n_s1b");
    cycle(2'd2, 1'b0, "n_s2b");
    cycle(2'd3, 1'b0, "n_s3b");
    check("hr_tens_1", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
    cycle(2'd0, 1'b0, "n_s0b");
    check("min_ones_5", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});

    bcd_time = 16'h0959;
    cycle(2'd1, 1'b0, "t_s1");
    cycle(2'd2, 1'b0, "t_s2");
    cycle(2'd3, 1'b0, "t_s3");
    check("tear_free_s3", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
    cycle(2'd0, 1'b0, "t_cap");
    cycle(2'd1, 1'b0, "t_s1b");
    cycle(2'd2, 1'b0, "t_s2b");
    cycle(2'd3, 1'b0, "t_s3b");
    check("new_frame_lz", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});

    blink_mask = 4'b0011;
    colon_en   = 1'b1;
    cycle(2'd0, 1'b0, "b1_s0");
    cycle(2'd1, 1'b0, "b1_s1");
    cycle(2'd2, 1'b0, "b1_s2");
    check("colon_on", {an, seg, dp}, {4'b1011, 7'b0010000, 1'b0});
    cycle(2'd3, 1'b1, "b1_s3");
    cycle(2'd0, 1'b0, "b0_s0");
    check("blink_s0", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    cycle(2'd1, 1'b0, "b0_s1");
    cycle(2'd2, 1'b0, "b0_s2");
    check("colon_off", {an, seg, dp}, {4'b1011, 7'b0010000, 1'b1});
    cycle(2'd3, 1'b1, "b0_s3");
    cycle(2'd0, 1'b0, "b2_s0");
    check("blink_visible", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

    blink_mask = 4'b0000;
    alarm_ring = 1'b1;
    cycle(2'd1, 1'b1, "a_s1");
    cycle(2'd2, 1'b0, "a_s2");
    check("alarm_dark", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    cycle(2'd3, 1'b0, "a_s3");
    cycle(2'd0, 1'b0, "a_s0");
    cycle(2'd1, 1'b0, "a_s1b");
    cycle(2'd2, 1'b1, "a_s2b");
    bcd_time = 16'h1A3F;
    cycle(2'd3, 1'b0, "a_s3b");
    cycle(2'd0, 1'b1, "a_cap_tick");
    cycle(2'd1, 1'b1, "a_s1c");
    alarm_ring = 1'b0;
    cycle(2'd2, 1'b0, "i_s2");
    check("dash_s2", {an, seg, dp}, {4'b1011, 7'b0111111, 1'b0});
    cycle(2'd0, 1'b0, "i_s0");
    check("dash_s0", {an, seg, dp}, {4'b1110, 7'b0111111, 1'b1});
    cycle(2'd3, 1'b0, "i_s3");
    cycle(2'd1, 1'b0, "i_jump_s1");
    check("nonseq_s1", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
